scene_sequencer: RTL and testbench
==================================

# scene_sequencer

Top-level scene controller for the VGA game pipeline. Sequences menu → fade-out → game start handshake → fade-in → play → fade back to menu. Arbitrates the menu and main-game pixel layers onto one RGB output, applying a per-frame brightness ramp. Sits between the menu renderer, the main game renderer and the VGA output register.

## Interface
- CORDW, 16, coordinate width, kept for pipeline consistency.
- FADE_SHIFT, 5, log2 of the number of frames per fade ramp (5 → 32 frames).
- MIN_HOLD_FRAMES, 60, minimum number of frames spent black in WAIT_READY.
- BG_COLOR, 24'h00FFFF, fallback colour when the active layer is not drawing, as {R,G,B}.

- i_clk_pix  in  1  pixel clock.
- i_rst_n  in  1  reset: synchronous, active-low; clock i_clk_pix.
- i_frame  in  1  one-cycle pulse at frame start.
- i_start  in  1  start button level.
- i_main_ready  in  1  main game loaded and ready.
- i_return_menu  in  1  main game requests return to menu.
- i_menu_drawing  in  1  menu layer pixel valid.
- i_menu_rgb  in  24  menu pixel {R,G,B}.
- i_main_drawing  in  1  main layer pixel valid.
- i_main_rgb  in  24  main pixel {R,G,B}.
- o_main_start  out  1  enables and holds the main game.
- o_menu_active  out  1  high in MENU and MENU_IN.
- o_state  out  3  current state encoding.
- o_drawing  out  1  registered valid of the selected layer.
- o_red, o_green, o_blue  out  8 each  registered output pixel.

## Operation
- States and encodings: MENU=0, FADE_OUT=1, WAIT_READY=2, FADE_IN=3, PLAY=4, RETURN_FADE=5, MENU_IN=6.
- Fade counter fcnt is FADE_SHIFT+1 bits wide. It clears on every state entry and increments only on i_frame. A fade state exits on the i_frame that makes fcnt = 2^FADE_SHIFT.
- Brightness b is registered on i_frame and held for the whole frame:
  - Down-ramps (FADE_OUT, RETURN_FADE): b = 2^FADE_SHIFT − fcnt.
  - Up-ramps (FADE_IN, MENU_IN): b = fcnt.
  - MENU and PLAY: b = 2^FADE_SHIFT.
  - WAIT_READY: b = 0.
- Channel output: (c × b) >> FADE_SHIFT, computed per channel at full width. The result saturates at 255.
- Transitions:
  - MENU → FADE_OUT on a rising edge of i_start.
  - FADE_OUT → WAIT_READY at the end of the ramp.
  - WAIT_READY → FADE_IN on any cycle where i_main_ready=1 and hcnt ≥ MIN_HOLD_FRAMES. hcnt counts i_frame pulses in WAIT_READY, saturates, and clears on entry.
  - FADE_IN → PLAY at the end of the ramp.
  - PLAY → RETURN_FADE when i_return_menu=1.
  - RETURN_FADE → MENU_IN at the end of the ramp.
  - MENU_IN → MENU at the end of the ramp.
- Layer selection:
  - MENU, FADE_OUT, MENU_IN use the menu layer.
  - FADE_IN, PLAY, RETURN_FADE use the main layer.
  - Pixel = drawing ? rgb : BG_COLOR.
  - WAIT_READY outputs black with o_drawing=0.
- o_main_start is registered. It is 1 from the cycle after WAIT_READY entry through RETURN_FADE, and drops on MENU_IN entry.
- Ignored inputs:
  - i_start outside MENU.
  - i_return_menu outside PLAY.
  - i_main_ready outside WAIT_READY; deassertion during FADE_IN or PLAY has no effect.
- The start edge detector resets to 1, so a button held through reset does not start the game.

## Timing
- Reset values:
  - State MENU; o_state=0.
  - o_main_start=0, o_menu_active=1, o_drawing=0.
  - RGB outputs 0.
  - fcnt=0, hcnt=0, b=2^FADE_SHIFT.
- Pixel latency is 1 cycle: the output at cycle n+1 reflects the layer inputs and b at cycle n.
- State registers update 1 cycle after the triggering condition.
- i_frame coincident with a state change: the new state's counter clears. That pulse does not count in the new state.
- Reset mid-operation overrides everything in the same edge. o_main_start drops on that edge.

## Configuration
- SCENE_FADE_EN defined: ramps and the multiply are implemented as above.
- SCENE_FADE_EN undefined:
  - Each fade state lasts until the next i_frame, then advances.
  - b is fixed at full scale everywhere except WAIT_READY, which stays black.
  - No multipliers are synthesised.
  - State sequence, encodings, handshake and latency are unchanged.

## Test plan
- Reset held 3 cycles with i_start=1, then released → stays MENU, o_main_start=0, o_state=0.
- FADE_SHIFT=2, menu pixel 24'hFF8040 drawing, i_start rising edge:
  - Frames output FF8040, BF6030, 7F4020, 3F2010.
  - Then WAIT_READY, output 000000.
- MIN_HOLD_FRAMES=3, i_main_ready=1 from WAIT_READY entry → FADE_IN on the cycle after the 3rd i_frame. o_main_start=1 throughout.
- PLAY, main not drawing → output 00FFFF. i_return_menu pulse → RETURN_FADE, then MENU_IN. o_main_start falls on MENU_IN entry.
- i_return_menu in WAIT_READY and i_start in PLAY → no state change.
- SCENE_FADE_EN undefined → FADE_OUT lasts exactly 1 frame with unscaled pixels.

Source files
------------

// File: rtl/scene_sequencer.sv
// Scene controller: menu -> fade-out -> game handshake -> fade-in -> play -> fade back to menu.
// SCENE_FADE_EN enables multi-frame brightness ramps; undefined, each fade state lasts one frame unscaled.
module scene_sequencer #(
    parameter int          CORDW           = 16,
    parameter int          FADE_SHIFT      = 5,
    parameter int          MIN_HOLD_FRAMES = 60,
    parameter logic [23:0] BG_COLOR        = 24'h00FFFF
) (
    input  logic        i_clk_pix,
    input  logic        i_rst_n,
    input  logic        i_frame,
    input  logic        i_start,
    input  logic        i_main_ready,
    input  logic        i_return_menu,
    input  logic        i_menu_drawing,
    input  logic [23:0] i_menu_rgb,
    input  logic        i_main_drawing,
    input  logic [23:0] i_main_rgb,
    output logic        o_main_start,
    output logic        o_menu_active,
    output logic [2:0]  o_state,
    output logic        o_drawing,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue
);

    localparam int            FW   = FADE_SHIFT + 1;
    localparam logic [FW-1:0] FULL = FW'(2 ** FADE_SHIFT);
`ifdef SCENE_FADE_EN
    localparam bit            FADE_EN   = 1'b1;
    localparam logic [FW-1:0] RAMP_LAST = FW'(2 ** FADE_SHIFT - 1);
`else
    localparam bit            FADE_EN   = 1'b0;
    localparam logic [FW-1:0] RAMP_LAST = '0;
`endif

    typedef enum logic [2:0] {
        MENU        = 3'd0,
        FADE_OUT    = 3'd1,
        WAIT_READY  = 3'd2,
        FADE_IN     = 3'd3,
        PLAY        = 3'd4,
        RETURN_FADE = 3'd5,
        MENU_IN     = 3'd6
    } state_t;

    state_t           state;
    logic [FW-1:0]    fcnt;
    logic [FW-1:0]    fcnt_inc;
    logic [FW-1:0]    b;
    logic [FW-1:0]    b_next;
    logic [CORDW-1:0] hcnt;
    logic             start_q;
    logic             ramp_done;
    logic             is_fade;
    logic             use_menu;
    logic             sel_draw;
    logic [23:0]      sel_rgb;
    logic [23:0]      px;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [FW-1:0] bb);
`ifdef SCENE_FADE_EN
        logic [FW+7:0] prod;
        logic [FW+7:0] sh;
        prod = {{FW{1'b0}}, c} * {8'h00, bb};
        sh   = prod >> FADE_SHIFT;
        return (|sh[FW+7:8]) ? 8'hFF : sh[7:0];
`else
        return (bb == '0) ? 8'h00 : c;
`endif
    endfunction

    // Fade brightness uses the count the frame is about to hold, so the exit frame lands on the next state's level.
    always_comb begin
        fcnt_inc  = fcnt + 1'b1;
        ramp_done = i_frame && (fcnt == RAMP_LAST);
        is_fade   = (state == FADE_OUT) || (state == FADE_IN) ||
                    (state == RETURN_FADE) || (state == MENU_IN);
        b_next    = FULL;
        case (state)
`ifdef SCENE_FADE_EN
            FADE_OUT, RETURN_FADE: b_next = FULL - fcnt_inc;
            FADE_IN, MENU_IN:      b_next = fcnt_inc;
`endif
            WAIT_READY:            b_next = '0;
            default:               b_next = FULL;
        endcase
    end

    always_ff @(posedge i_clk_pix) begin
        if (!i_rst_n) begin
            state        <= MENU;
            fcnt         <= '0;
            hcnt         <= '0;
            b            <= FULL;
            start_q      <= 1'b1;
            o_main_start <= 1'b0;
        end else begin
            start_q <= i_start;
            if (i_frame) b <= b_next;
            if (is_fade && i_frame) fcnt <= fcnt_inc;
            if (state == WAIT_READY && i_frame && hcnt != '1) hcnt <= hcnt + 1'b1;
            case (state)
                MENU: if (i_start && !start_q) begin
                    state <= FADE_OUT;
                    fcnt  <= '0;
                end
                FADE_OUT: if (ramp_done) begin
                    state <= WAIT_READY;
                    fcnt  <= '0;
                    hcnt  <= '0;
                end
                WAIT_READY: begin
                    o_main_start <= 1'b1;
                    if (i_main_ready && hcnt >= CORDW'(MIN_HOLD_FRAMES)) begin
                        state <= FADE_IN;
                        fcnt  <= '0;
                        if (!FADE_EN) b <= FULL;
                    end
                end
                FADE_IN: if (ramp_done) begin
                    state <= PLAY;
                    fcnt  <= '0;
                end
                PLAY: if (i_return_menu) begin
                    state <= RETURN_FADE;
                    fcnt  <= '0;
                end
                RETURN_FADE: if (ramp_done) begin
                    state        <= MENU_IN;
                    fcnt         <= '0;
                    o_main_start <= 1'b0;
                end
                MENU_IN: if (ramp_done) begin
                    state <= MENU;
                    fcnt  <= '0;
                end
                default: state <= MENU;
            endcase
        end
    end

    always_comb begin
        use_menu = (state == MENU) || (state == FADE_OUT) || (state == MENU_IN);
        sel_draw = use_menu ? i_menu_drawing : i_main_drawing;
        sel_rgb  = use_menu ? i_menu_rgb : i_main_rgb;
        px       = sel_draw ? sel_rgb : BG_COLOR;
    end

    always_ff @(posedge i_clk_pix) begin
        if (!i_rst_n || state == WAIT_READY) begin
            o_drawing <= 1'b0;
            o_red     <= '0;
            o_green   <= '0;
            o_blue    <= '0;
        end else begin
            o_drawing <= sel_draw;
            o_red     <= scale(px[23:16], b);
            o_green   <= scale(px[15:8], b);
            o_blue    <= scale(px[7:0], b);
        end
    end

    assign o_state       = state;
    assign o_menu_active = (state == MENU) || (state == MENU_IN);

endmodule

// File: tb/tb_scene_sequencer.sv
// Scoreboard bench for scene_sequencer with FADE_SHIFT=2 and MIN_HOLD_FRAMES=3.
module tb_scene_sequencer;

`ifdef SCENE_FADE_EN
    localparam bit FADE_EN = 1'b1;
`else
    localparam bit FADE_EN = 1'b0;
`endif
    localparam int NSTEP = FADE_EN ? 4 : 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame = 1'b0;
    logic        start = 1'b1;
    logic        main_ready = 1'b0;
    logic        return_menu = 1'b0;
    logic        menu_drawing = 1'b1;
    logic [23:0] menu_rgb = 24'hFF8040;
    logic        main_drawing = 1'b1;
    logic [23:0] main_rgb = 24'h4080C0;
    logic        main_start;
    logic        menu_active;
    logic [2:0]  state;
    logic        drawing;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [24:0] px_q[$];
    string       tag_q[$];

    scene_sequencer #(
        .FADE_SHIFT(2),
        .MIN_HOLD_FRAMES(3)
    ) dut (
        .i_clk_pix(clk),
        .i_rst_n(rst_n),
        .i_frame(frame),
        .i_start(start),
        .i_main_ready(main_ready),
        .i_return_menu(return_menu),
        .i_menu_drawing(menu_drawing),
        .i_menu_rgb(menu_rgb),
        .i_main_drawing(main_drawing),
        .i_main_rgb(main_rgb),
        .o_main_start(main_start),
        .o_menu_active(menu_active),
        .o_state(state),
        .o_drawing(drawing),
        .o_red(red),
        .o_green(green),
        .o_blue(blue)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; any pixel pushed before the edge is compared against the registered output after it.
    task automatic tick(input logic frm);
        logic [24:0] e;
        string       t;
        frame = frm;
        @(posedge clk);
        #1;
        frame = 1'b0;
        if (px_q.size() > 0) begin
            e = px_q.pop_front();
            t = tag_q.pop_front();
            check_eq(t, 32'({drawing, red, green, blue}), 32'(e));
        end
    endtask

    task automatic expect_px(input string tag, input logic [24:0] val);
        px_q.push_back(val);
        tag_q.push_back(tag);
        tick(1'b0);
    endtask

    task automatic run_fade(input string tag, input logic [2:0] st, input logic [2:0] nxt,
                            input logic [23:0] e0, input logic [23:0] e1,
                            input logic [23:0] e2, input logic [23:0] e3, input logic dr);
        logic [23:0] tbl[4];
        tbl[0] = e0;
        tbl[1] = e1;
        tbl[2] = e2;
        tbl[3] = e3;
        for (int k = 0; k < NSTEP; k++) begin
            expect_px({tag, "_px"}, {dr, tbl[k]});
            expect_px({tag, "_px"}, {dr, tbl[k]});
            check_eq({tag, "_state"}, 32'(state), 32'(st));
            tick(1'b1);
        end
        check_eq({tag, "_exit"}, 32'(state), 32'(nxt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit found;

        // Reset held with start asserted
        repeat (3) tick(1'b0);
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_main_start", 32'(main_start), 32'd0);
        check_eq("rst_menu_active", 32'(menu_active), 32'd1);
        check_eq("rst_pixel", 32'({drawing, red, green, blue}), 32'd0);
        rst_n = 1'b1;
        expect_px("menu_px", {1'b1, 24'hFF8040});
        expect_px("menu_px", {1'b1, 24'hFF8040});
        check_eq("held_start_state", 32'(state), 32'd0);
        check_eq("held_start_ms", 32'(main_start), 32'd0);

        // Start edge
        start = 1'b0;
        expect_px("menu_px", {1'b1, 24'hFF8040});
        start = 1'b1;
        expect_px("menu_px", {1'b1, 24'hFF8040});
        check_eq("start_state", 32'(state), 32'd1);
        check_eq("fout_menu_active", 32'(menu_active), 32'd0);
        run_fade("fout", 3'd1, 3'd2, 24'hFF8040, 24'hBF6030, 24'h7F4020, 24'h3F2010, 1'b1);

        // WAIT_READY handshake
        check_eq("wr_entry_ms", 32'(main_start), 32'd0);
        main_ready  = 1'b1;
        return_menu = 1'b1;
        expect_px("wr_px", {1'b0, 24'h000000});
        return_menu = 1'b0;
        check_eq("wr_ms", 32'(main_start), 32'd1);
        check_eq("wr_ignore_return", 32'(state), 32'd2);
        for (int j = 0; j < 3; j++) begin
            expect_px("wr_px", {1'b0, 24'h000000});
            check_eq("wr_hold", 32'(state), 32'd2);
            tick(1'b1);
        end
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            if (state == 3'd3) found = 1'b1;
            else tick(1'b0);
        end
        check_eq("wr_to_fade_in", 32'(found), 32'd1);
        main_ready = 1'b0;
        run_fade("fin", 3'd3, 3'd4, FADE_EN ? 24'h000000 : 24'h4080C0,
                 24'h102030, 24'h204060, 24'h306090, 1'b1);

        // PLAY
        expect_px("play_px", {1'b1, 24'h4080C0});
        check_eq("play_ms", 32'(main_start), 32'd1);
        main_drawing = 1'b0;
        expect_px("play_bg", {1'b0, 24'h00FFFF});
        start = 1'b0;
        expect_px("play_bg", {1'b0, 24'h00FFFF});
        start = 1'b1;
        expect_px("play_bg", {1'b0, 24'h00FFFF});
        tick(1'b0);
        check_eq("play_ignore_start", 32'(state), 32'd4);
        return_menu = 1'b1;
        tick(1'b0);
        return_menu = 1'b0;
        check_eq("return_state", 32'(state), 32'd5);
        run_fade("ret", 3'd5, 3'd6, 24'h00FFFF, 24'h00BFBF, 24'h007F7F, 24'h003F3F, 1'b0);
        check_eq("menu_in_ms", 32'(main_start), 32'd0);
        check_eq("menu_in_active", 32'(menu_active), 32'd1);
        run_fade("min", 3'd6, 3'd0, FADE_EN ? 24'h000000 : 24'hFF8040,
                 24'h3F2010, 24'h7F4020, 24'hBF6030, 1'b1);
        expect_px("menu_again_px", {1'b1, 24'hFF8040});

        // Reset in the middle of a fade
        start = 1'b0;
        tick(1'b0);
        start = 1'b1;
        tick(1'b0);
        check_eq("restart_state", 32'(state), 32'd1);
        rst_n = 1'b0;
        tick(1'b0);
        check_eq("midrst_state", 32'(state), 32'd0);
        check_eq("midrst_pixel", 32'({drawing, red, green, blue}), 32'd0);
        rst_n = 1'b1;
        tick(1'b0);
        check_eq("midrst_no_restart", 32'(state), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
